uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART serial transmitter, the stage directly downstream of the baud clock divider.
//  - Takes the divider's baud_clk level (toggles every 14 clk_in, bit period 28 clk_in).
//  - Edge-detects it in the clk_in domain. The design stays single-clock.
//  - Shifts out one framed character per valid/ready handshake, LSB first.
// PARAMETERS
//  DATA_BITS   8  data bits per frame, legal 5..9
//  PARITY_EN   0  1 = insert parity bit after data
//  PARITY_ODD  0  1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//  STOP_BITS   1  stop bits, legal 1..2
// PORTS
//  clk_in    in   1          system clock, all logic on posedge
//  rst_n     in   1          async active-low reset
//  baud_clk  in   1          baud square wave from divider, synchronous to clk_in
//  tx_data   in   DATA_BITS  character to send, sampled only on accept
//  tx_valid  in   1          upstream has a character
//  tx_ready  out  1          block can accept (high only in IDLE)
//  tx_busy   out  1          frame in progress (== ~tx_ready)
//  tx        out  1          serial line, idle high, registered
// BEHAVIOUR
//  Reset, async, any state:
//  - tx=1, tx_ready=1, tx_busy=0, state=IDLE.
//  - shift reg, bit_cnt and stop_cnt cleared; baud_d=0.
//  baud_tick = baud_clk & ~baud_d, with baud_d registered each cycle.
//  - One-cycle pulse per baud_clk rising edge.
//  - A tick landing in IDLE is ignored, so a spurious tick after reset release is harmless.
//  Accept = tx_valid & tx_ready. On accept:
//  - latch tx_data, compute parity (^data ^ PARITY_ODD), go to SYNC.
//  - tx_ready falls the next cycle.
//  - tx_valid while busy is ignored; tx_data changes after accept have no effect.
//  FSM; all transitions only on a cycle with baud_tick, tx updated on that same edge:
//  - IDLE:   tx=1; accept -> SYNC.
//  - SYNC:   tx=1 (waits for bit alignment); tick -> START, tx<=0.
//  - START:  tick -> DATA, tx<=d[0], bit_cnt<=0.
//  - DATA:   tick with bit_cnt<DATA_BITS-1 -> tx<=d[bit_cnt+1], bit_cnt++.
//            bit_cnt==DATA_BITS-1 -> PARITY (tx<=par) if PARITY_EN, else STOP (tx<=1, stop_cnt<=0).
//  - PARITY: tick -> STOP, tx<=1, stop_cnt<=0.
//  - STOP:   tick with stop_cnt==STOP_BITS-1 -> IDLE; otherwise stop_cnt++. tx held 1.
//  Every bit is held for exactly one baud_tick interval (28 clk_in with the divider).
//  Latency, counting the first tick after accept as tick 1:
//  - start bit begins at tick 1.
//  - 8N1 frame: data at ticks 2..9, stop at tick 10, IDLE after tick 11.
//  - tx_ready high on the cycle after tick 11.
//  Back-to-back: an accept in the first IDLE cycle waits in SYNC for the next tick.
//  - No line idle beyond the stop bits other than that wait.
//  baud_clk stuck at a level: the FSM holds its state, tx holds its value.
//  Reset mid-frame: tx returns high immediately (async); the frame is truncated, not resumed.
// TESTING
//  1. 8N1, baud_clk period 28, send 0xA5.
//     -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 28 clk_in; tx_ready high 1 cycle after tick 11.
//  2. Hold tx_valid high with 0x3C then 0xC3.
//     -> two contiguous frames; the second start bit begins at the first tick after re-accept.
//  3. PARITY_EN=1, even, send 0x07.
//     -> parity bit = 1 after d7; PARITY_ODD=1 gives 0. Frame is 11 bit periods.
//  4. Assert rst_n low mid-DATA of 0xFF.
//     -> tx=1 and tx_ready=1 asynchronously; after release, the next accept sends a full clean frame.
//  5. During a frame, pulse tx_valid with 0x55 and change tx_data.
//     -> ignored; transmitted bits match the originally accepted byte.
//  6. Accept 0x81 with baud_clk held low for 500 cycles.
//     -> tx stays 1 in SYNC; the start bit begins on the first rising edge afterwards.

Source files
------------

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Purpose  : Character handshake between an upstream producer and uart_tx.
// Revision : 1.0
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Framed UART transmitter paced by an edge-detected baud square wave.
// Revision : 1.0
// ============================================================================
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  wire logic clk_in,
    input  wire logic rst_n,
    input  wire logic baud_clk,
    uart_tx_if.slave  bus,
    output logic      tx
);
    localparam int                 C_CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST_BIT  = C_CNT_W'(DATA_BITS - 1);
    localparam logic               C_LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic               C_PAR_ODD   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic [C_CNT_W-1:0]   r_bit_cnt;
    logic [C_CNT_W-1:0]   w_bit_cnt_nxt;
    logic                 r_stop_cnt;
    logic                 w_stop_cnt_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_baud_d;
    logic                 w_baud_tick;
    logic                 w_accept;

    // One-cycle pulse per rising edge of the divider output.
    assign w_baud_tick = baud_clk & ~r_baud_d;
    assign w_accept    = bus.tx_valid & (r_state == S_IDLE);

    assign bus.tx_ready = (r_state == S_IDLE);
    assign bus.tx_busy  = (r_state != S_IDLE);
    assign tx           = r_tx;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_baud_d   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_baud_d   <= baud_clk;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_par_nxt      = r_par;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_tx_nxt       = r_tx;

        case (r_state)
            S_IDLE: begin
                // Ticks are ignored here; a frame always starts by waiting in SYNC.
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_shift_nxt = bus.tx_data;
                    w_par_nxt   = (^bus.tx_data) ^ C_PAR_ODD;
                    w_state_nxt = S_SYNC;
                end
            end

            S_SYNC: begin
                if (w_baud_tick) begin
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end

            S_START: begin
                if (w_baud_tick) begin
                    w_state_nxt   = S_DATA;
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = '0;
                end
            end

            S_DATA: begin
                if (w_baud_tick) begin
                    if (r_bit_cnt == C_LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt    = S_STOP;
                            w_tx_nxt       = 1'b1;
                            w_stop_cnt_nxt = 1'b0;
                        end
                    end else begin
                        // The shifter has already advanced, so bit 0 is the next data bit.
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + C_CNT_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (w_baud_tick) begin
                    w_state_nxt    = S_STOP;
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                end
            end

            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_tick) begin
                    if (r_stop_cnt == C_LAST_STOP) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Frame-level reference model bench for three uart_tx configurations.
// Revision : 1.0
// ============================================================================
module tb_uart_tx;
    localparam int NI = 3;

    logic       clk_in   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       baud_clk = 1'b0;
    logic       baud_en  = 1'b1;
    logic       valid    = 1'b0;
    logic [8:0] data     = '0;
    logic       chk_en   = 1'b0;
    int         tests    = 0;
    int         fails    = 0;

    logic            tx0, tx1, tx2;
    logic [NI-1:0]   tx_v, rdy_v, bsy_v;

    uart_tx_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_if #(.DATA_BITS(7)) bus2 ();

    assign bus0.tx_valid = valid;
    assign bus1.tx_valid = valid;
    assign bus2.tx_valid = valid;
    assign bus0.tx_data  = data[7:0];
    assign bus1.tx_data  = data[7:0];
    assign bus2.tx_data  = data[6:0];

    assign tx_v  = {tx2, tx1, tx0};
    assign rdy_v = {bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};
    assign bsy_v = {bus2.tx_busy, bus1.tx_busy, bus0.tx_busy};

    // 8N1, 8E1 and 7O2 side by side on the same baud wave and stimulus.
    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .baud_clk(baud_clk), .bus(bus0), .tx(tx0));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk_in(clk_in), .rst_n(rst_n), .baud_clk(baud_clk), .bus(bus1), .tx(tx1));
    uart_tx #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .clk_in(clk_in), .rst_n(rst_n), .baud_clk(baud_clk), .bus(bus2), .tx(tx2));

    function automatic int cfg_db(int i);
        return (i == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_pe(int i);
        return (i == 0) ? 0 : 1;
    endfunction
    function automatic int cfg_po(int i);
        return (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int nbits(int i);
        return 1 + cfg_db(i) + cfg_pe(i) + cfg_sb(i);
    endfunction

    // Line levels of one frame in transmit order, bit 0 first; unused tail is idle-high.
    function automatic logic [15:0] frame_of(int i, logic [8:0] d);
        logic [15:0] f;
        int          ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int j = 0; j < cfg_db(i); j++) begin
            f[1 + j] = d[j];
            ones     = ones + int'(d[j]);
        end
        if (cfg_pe(i) != 0) f[1 + cfg_db(i)] = 1'((ones % 2) ^ cfg_po(i));
        return f;
    endfunction

    // Reference model state: per instance, a frame and how many ticks into it we are.
    logic        m_busy [NI];
    int          m_idx  [NI];
    logic [15:0] m_frm  [NI];
    logic        m_line [NI];
    logic        m_bprev;

    task automatic model_reset();
        m_bprev = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 1'b0;
            m_idx[i]  = 0;
            m_frm[i]  = '1;
            m_line[i] = 1'b1;
        end
    endtask

    task automatic model_step();
        logic tick;
        tick    = baud_clk & ~m_bprev;
        m_bprev = baud_clk;
        for (int i = 0; i < NI; i++) begin
            if (!m_busy[i]) begin
                m_line[i] = 1'b1;
                if (valid) begin
                    m_frm[i]  = frame_of(i, data);
                    m_busy[i] = 1'b1;
                    m_idx[i]  = -1;
                end
            end else if (tick) begin
                m_idx[i] = m_idx[i] + 1;
                if (m_idx[i] < nbits(i)) begin
                    m_line[i] = m_frm[i][m_idx[i]];
                end else begin
                    m_busy[i] = 1'b0;
                    m_line[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h need %0h at %0t", nm, got, exp, $time);
        end
    endtask

    initial forever #5 clk_in = ~clk_in;

    // Divider stand-in: toggles every 14 clk_in unless frozen.
    initial begin
        forever begin
            repeat (14) @(negedge clk_in);
            #1;
            if (baud_en) baud_clk = ~baud_clk;
        end
    end

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (chk_en) begin
                for (int i = 0; i < NI; i++) begin
                    tests = tests + 1;
                    if ({tx_v[i], rdy_v[i], bsy_v[i]} !== {m_line[i], ~m_busy[i], m_busy[i]}) begin
                        fails = fails + 1;
                        $display("FAIL cycle dut%0d: got tx/rdy/busy=%b%b%b need %b%b%b at %0t",
                                 i, tx_v[i], rdy_v[i], bsy_v[i], m_line[i], ~m_busy[i], m_busy[i], $time);
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_all_idle(input string nm);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_in);
            #1;
            if (rdy_v == 3'b111) return;
        end
        chk({nm, "_idle_timeout"}, 32'(rdy_v), 32'h7);
    endtask

    task automatic send(input logic [8:0] d);
        data  = d;
        valid = 1'b1;
        @(negedge clk_in);
        #1;
        valid = 1'b0;
    endtask

    logic [15:0] fr;
    logic [9:0]  seq;
    bit          seen;

    initial begin
        repeat (3) @(negedge clk_in);
        chk("reset_state", {23'd0, tx_v, rdy_v, bsy_v}, 32'b111_111_000);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Hand-derived frames pin the model.
        fr = frame_of(0, 9'h0A5);
        chk("pin_8n1_a5", 32'(fr[9:0]), 32'h34A);
        fr = frame_of(1, 9'h007);
        chk("pin_even_par_07", 32'(fr[9]), 32'h1);
        fr = frame_of(2, 9'h007);
        chk("pin_odd_par_07", 32'(fr[8]), 32'h0);
        chk("pin_8e1_len", 32'(nbits(1)), 32'd11);

        // 0xA5 on the 8N1 line, sampled mid-bit.
        wait_all_idle("t1");
        send(9'h0A5);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk_in);
            if (tx_v[0] == 1'b0) seen = 1'b1;
        end
        chk("t1_start_seen", 32'(seen), 32'h1);
        for (int k = 0; k < 10; k++) begin
            repeat (14) @(negedge clk_in);
            seq[k] = tx_v[0];
            repeat (14) @(negedge clk_in);
        end
        chk("t1_a5_serial", 32'(seq), 32'h34A);

        // Parity frames for 0x07.
        wait_all_idle("t3");
        send(9'h007);

        // Back-to-back with tx_valid held high.
        wait_all_idle("t2");
        data  = 9'h03C;
        valid = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_in); #1;
            if (!rdy_v[0]) seen = 1'b1;
        end
        chk("t2_first_accept", 32'(seen), 32'h1);
        data = 9'h0C3;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk_in); #1;
            if (rdy_v[0]) seen = 1'b1;
        end
        chk("t2_ready_return", 32'(seen), 32'h1);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk_in); #1;
            if (!rdy_v[0]) seen = 1'b1;
        end
        chk("t2_second_accept", 32'(seen), 32'h1);
        valid = 1'b0;

        // Valid pulses and data changes mid-frame are ignored.
        wait_all_idle("t5");
        send(9'h00F);
        data = 9'h1AA;
        repeat (100) @(negedge clk_in);
        #1;
        send(9'h055);
        data = 9'h133;

        // Asynchronous reset in the middle of 0xFF.
        wait_all_idle("t4");
        send(9'h0FF);
        repeat (140) @(negedge clk_in);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t4_async_tx", 32'(tx_v), 32'h7);
        chk("t4_async_rdy", 32'(rdy_v), 32'h7);
        repeat (3) @(negedge clk_in);
        #1;
        rst_n = 1'b1;
        send(9'h0FF);
        wait_all_idle("t4b");

        // Stalled baud clock holds the frame in SYNC.
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk_in); #2;
            if (baud_clk == 1'b0) begin
                baud_en = 1'b0;
                seen    = 1'b1;
            end
        end
        send(9'h081);
        repeat (500) @(negedge clk_in);
        chk("t6_stall_line", 32'({tx_v[0], rdy_v[0]}), 32'b10);
        #2;
        baud_en = 1'b1;
        wait_all_idle("t6");

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_in); #1;
            valid = ($urandom_range(0, 3) == 0);
            data  = 9'($urandom);
        end
        valid = 1'b0;
        wait_all_idle("rand");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
